// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: funct3 load/store encodings, LSU fault causes,
// LSU state encoding and the request legality check.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } lsu_state_t;

   // Illegal encodings take priority over misalignment.
   function automatic logic [1:0] lsu_check(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic illegal;
      logic mis;
      if (we) illegal = f3[2] | (f3[1:0] == 2'b11);
      else    illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = |off;
         default: mis = 1'b0;
      endcase
      if (illegal)  return CAUSE_ILLEGAL;
      else if (mis) return CAUSE_MISALIGN;
      else          return CAUSE_NONE;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction / sign or zero extension for loads.
module lsu_align
   import riscv_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load
);

   logic [31:0] w_shift;

   assign w_shift = i_mem_rdata >> {i_off, 3'b000};

   always_comb begin
      o_be    = '1;
      o_wdata = i_wdata;
      if (i_we) begin
         case (i_funct3)
            F3_SB: begin
               o_be    = 4'b0001 << i_off;
               o_wdata = {4{i_wdata[7:0]}};
            end
            F3_SH: begin
               o_be    = i_off[1] ? 4'b1100 : 4'b0011;
               o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (i_funct3)
         F3_LB:   o_load = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_LH:   o_load = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_LBU:  o_load = {24'd0, w_shift[7:0]};
         F3_LHU:  o_load = {16'd0, w_shift[15:0]};
         default: o_load = w_shift;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one req/ack data-memory transaction per start, with
// alignment/legality faults, an ack-wait timeout and extended load data.
module lsu
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_cnt;
   logic [31:0] r_rdata;
   logic [1:0]  r_cause;
   logic [1:0]  w_start_cause;
   logic        w_timeout;
   logic        w_req;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_load;

   assign w_start_cause = lsu_check(we, funct3, addr[1:0]);
   assign w_timeout     = (TIMEOUT != 0) && ((r_cnt + 32'd1) == TIMEOUT);
   assign w_req         = (r_state == ST_REQ);

   lsu_align u_align (
      .i_we        (r_we),
      .i_funct3    (r_f3),
      .i_off       (r_addr[1:0]),
      .i_wdata     (r_wdata),
      .i_mem_rdata (mem_rdata),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_load      (w_load)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = (w_start_cause == CAUSE_NONE) ? ST_REQ : ST_DONE;
         ST_REQ:  if (mem_ack || w_timeout) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_cause <= CAUSE_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (start) begin
                  r_we    <= we;
                  r_f3    <= funct3;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cause <= w_start_cause;
               end
            end
            ST_REQ: begin
               // ack wins over a timeout expiring in the same cycle
               if (mem_ack) begin
                  if (!r_we) r_rdata <= w_load;
               end else if (w_timeout) begin
                  r_cause <= CAUSE_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign fault       = done && (r_cause != CAUSE_NONE);
   assign fault_cause = done ? r_cause : CAUSE_NONE;
   assign rdata       = r_rdata;
   assign mem_req     = w_req;
   assign mem_we      = w_req && r_we;
   assign mem_addr    = w_req ? {r_addr[31:2], 2'b00} : '0;
   assign mem_be      = w_req ? w_be : '0;
   assign mem_wdata   = w_req ? w_wdata : '0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: transaction-level reference model, per-cycle compare,
// directed scenarios plus randomized accesses with bus and start noise.
module tb_lsu;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int errors = 0;
   int checks = 0;

   logic        cmp_en = 1'b0;
   logic        e_busy, e_done, e_fault, e_req, e_we;
   logic [1:0]  e_cause;
   logic [31:0] e_rdata, e_addr, e_wdata;
   logic [3:0]  e_be;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .we          (we),
      .funct3      (funct3),
      .addr        (addr),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .rdata       (rdata),
      .fault       (fault),
      .fault_cause (fault_cause),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic logic [1:0] model_cause(input logic w, input logic [2:0] f, input logic [31:0] a);
      bit ok;
      if (w) ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
      else   ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
      if (!ok) return 2'd2;
      if ((a % acc_size(f)) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [3:0] model_be(input logic w, input logic [2:0] f, input logic [31:0] a);
      int b;
      if (!w) return 4'hF;
      b = ((1 << acc_size(f)) - 1) << (a % 4);
      return b[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] wd);
      logic [31:0] r;
      int sz;
      sz = acc_size(f);
      for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      logic [31:0] mask;
      int bits;
      v = rd >> (8 * (a % 4));
      bits = 8 * acc_size(f);
      if (bits == 32) return v;
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!f[2] && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("fault", fault, e_fault);
         chk("fault_cause", fault_cause, e_cause);
         chk("mem_req", mem_req, e_req);
         chk("rdata", rdata, e_rdata);
         if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be", mem_be, e_be);
            chk("mem_wdata", mem_wdata, e_wdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b0; e_cause = 2'd0; e_req = 1'b0;
   endtask

   task automatic noise_inputs(input bit noise);
      if (noise) begin
         start  = 1'($urandom_range(0, 1));
         we     = 1'($urandom_range(0, 1));
         funct3 = 3'($urandom_range(0, 7));
         addr   = $urandom;
         wdata  = $urandom;
      end else begin
         start = 1'b0;
      end
   endtask

   // Called in an IDLE cycle; returns in the first IDLE cycle after retire.
   task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] rdv,
                         input bit noise);
      logic [1:0] c;
      bit acked;
      int i;
      start = 1'b1; we = w; funct3 = f; addr = a; wdata = wd;
      mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      tick();
      c = model_cause(w, f, a);
      if (c != 2'd0) begin
         e_busy = 1'b1; e_done = 1'b1; e_fault = 1'b1; e_cause = c; e_req = 1'b0;
         noise_inputs(noise);
         mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end else begin
         acked = 0;
         i = 0;
         while (i < 64) begin
            e_busy = 1'b1; e_done = 1'b0; e_fault = 1'b0; e_cause = 2'd0; e_req = 1'b1;
            e_we = w; e_addr = {a[31:2], 2'b00}; e_be = model_be(w, f, a);
            e_wdata = w ? model_wdata(f, wd) : wd;
            noise_inputs(noise);
            if (i == waits) begin
               mem_ack = 1'b1; mem_rdata = rdv; acked = 1;
            end else begin
               mem_ack = 1'b0; mem_rdata = $urandom;
            end
            tick();
            if (acked) break;
            if (TMO != 0 && i + 1 == TMO) break;
            i++;
         end
         e_busy = 1'b1; e_done = 1'b1; e_req = 1'b0;
         e_fault = !acked;
         e_cause = acked ? 2'd0 : 2'd3;
         if (acked && !w) e_rdata = model_load(f, a, rdv);
         noise_inputs(noise);
         // late ack after a timeout must have no effect
         mem_ack = (!acked || noise) ? 1'b1 : 1'b0;
         mem_rdata = $urandom;
         tick();
      end
      set_idle();
      start = 1'b0;
      mem_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      set_idle();
      e_rdata = '0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
      #1;
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", mem_be, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_we", mem_we, 32'h0);
      cmp_en = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // model pins
      chk("pin_SH_be", model_be(1'b1, 3'd1, 32'h42), 32'hC);
      chk("pin_SH_wd", model_wdata(3'd1, 32'h0000ABCD), 32'hABCDABCD);
      chk("pin_SB_be", model_be(1'b1, 3'd0, 32'h3), 32'h8);
      chk("pin_LB", model_load(3'd0, 32'h203, 32'h80FF1234), 32'hFFFFFF80);
      chk("pin_LW_mis", model_cause(1'b0, 3'd2, 32'h101), 32'h1);
      chk("pin_S100", model_cause(1'b1, 3'd4, 32'h101), 32'h2);

      // directed scenarios
      access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 3, 32'h0, 0);
      access(1'b0, 3'd0, 32'h203, 32'h0, 0, 32'h80FF1234, 0);
      chk("LB_rdata", rdata, 32'hFFFFFF80);
      access(1'b0, 3'd4, 32'h203, 32'h0, 0, 32'h80FF1234, 0);
      chk("LBU_rdata", rdata, 32'h00000080);
      access(1'b1, 3'd1, 32'h42, 32'h0000ABCD, 1, 32'h0, 0);
      access(1'b0, 3'd5, 32'h42, 32'h0, 0, 32'hBEEF0000, 0);
      chk("LHU_rdata", rdata, 32'h0000BEEF);
      access(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0, 0);
      chk("LW_mis_rdata", rdata, 32'h0000BEEF);
      access(1'b1, 3'd4, 32'h40, 32'h1, 0, 32'h0, 0);
      access(1'b1, 3'd2, 32'h300, 32'h11223344, 20, 32'h0, 0);
      access(1'b1, 3'd2, 32'h304, 32'h55667788, 20, 32'h0, 1);

      // reset during REQ
      start = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h80; wdata = 32'hCAFEF00D;
      tick();
      start = 1'b0;
      e_busy = 1'b1; e_req = 1'b1; e_we = 1'b1; e_addr = 32'h80; e_be = 4'hF; e_wdata = 32'hCAFEF00D;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_req", mem_req, 32'h0);
      chk("rst_mid_busy", busy, 32'h0);
      chk("rst_mid_done", done, 32'h0);
      set_idle();
      e_rdata = '0;
      tick();
      reset = 1'b0;
      access(1'b0, 3'd2, 32'h0, 32'h0, 0, 32'h12345678, 0);
      chk("LW_after_rst", rdata, 32'h12345678);

      // randomized accesses
      for (int n = 0; n < 250; n++) begin
         logic [31:0] ra;
         ra = {20'h0, 12'($urandom)};
         access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                int'($urandom_range(0, 5)), $urandom, n[0]);
         if ($urandom_range(0, 3) == 0) begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            mem_ack = 1'b0;
         end
      end

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
